// File: rtl/irq_request_latch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared defaults and FSM state encoding for the interrupt
//               request latch that feeds the 8-input priority encoder.
// Contents    : N_IRQ_DEF, CODE_W_DEF, SYNC_STAGES_DEF, irq_state_t
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

  localparam int N_IRQ_DEF       = 8;
  localparam int CODE_W_DEF      = 3;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } irq_state_t;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_request_latch_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_edge_sync
// Description : One interrupt line: SYNC_STAGES-deep synchroniser, a delay
//               flop and a single-cycle rising-edge pulse.
// Ports       : clk     - system clock, rising edge
//               rst_n   - asynchronous active-low reset
//               irq_i   - raw asynchronous interrupt line
//               set_o   - one-cycle pulse on a synchronised 0->1 edge
// Revision    : 1.0 - initial release
// ============================================================================
module irq_edge_sync
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  output logic set_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   dly_q;
  // Arming shift register: the synchroniser and delay flops come out of reset
  // at 0, so a line that is already high would otherwise look like a fresh
  // edge. Edge reporting is held off until the delay flop has caught up with
  // the real line level (SYNC_STAGES+1 clocks after reset release).
  logic [SYNC_STAGES:0]   arm_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= sync_q[SYNC_STAGES-1];
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign set_o = sync_q[SYNC_STAGES-1] & ~dly_q & arm_q[SYNC_STAGES];

endmodule : irq_edge_sync
`default_nettype wire

// File: rtl/irq_request_latch.sv
`default_nettype none
// ============================================================================
// Module      : irq_request_latch
// Description : Synchronises raw interrupt lines, latches rising edges as
//               sticky pending bits, presents the masked vector to the
//               priority encoder and handshakes with the consumer. An ack
//               carries the encoder code back and clears that pending bit.
// Ports       : clk            - system clock, rising edge
//               rst_n          - asynchronous active-low reset
//               ovr_clr_i      - clear overrun counter (IRQ_OVERRUN_CNT_EN)
//               overrun_cnt_o  - saturating overrun count (IRQ_OVERRUN_CNT_EN)
//               irq_in_i       - raw asynchronous interrupt lines
//               mask_i         - 1 = line enabled
//               pend_out_o     - pending & mask, encoder input
//               irq_valid_o    - request to consumer (state == REQ)
//               ack_i          - consumer accepts current request
//               ack_code_i     - index being serviced
//               pending_raw_o  - unmasked pending register
// Options     : `define IRQ_OVERRUN_CNT_EN adds the overrun counter and its
//               two ports; without it neither exists.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_request_latch
  import irq_pkg::*;
#(
  parameter int N_IRQ       = N_IRQ_DEF,
  parameter int CODE_W      = CODE_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef IRQ_OVERRUN_CNT_EN
  input  logic              ovr_clr_i,
  output logic [7:0]        overrun_cnt_o,
`endif
  input  logic [N_IRQ-1:0]  irq_in_i,
  input  logic [N_IRQ-1:0]  mask_i,
  output logic [N_IRQ-1:0]  pend_out_o,
  output logic              irq_valid_o,
  input  logic              ack_i,
  input  logic [CODE_W-1:0] ack_code_i,
  output logic [N_IRQ-1:0]  pending_raw_o
);

  logic [N_IRQ-1:0] set_vec;
  logic [N_IRQ-1:0] clr_vec;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] pending_d;
  logic [N_IRQ-1:0] pend_masked;
  logic             ack_ok;
  irq_state_t       state_q;

  // --------------------------------------------------------------------------
  // Per-line synchroniser and edge detector
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
    irq_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .irq_i (irq_in_i[gi]),
      .set_o (set_vec[gi])
    );
  end

  assign pend_masked = pending_q & mask_i;

  // --------------------------------------------------------------------------
  // Acknowledge decode and pending next state. A code beyond N_IRQ-1 is not a
  // valid acknowledge at all (no clear, no HOLD). Set is OR-ed in after the
  // clear so a coincident new edge on the serviced line survives.
  // --------------------------------------------------------------------------
  always_comb begin
    ack_ok  = 1'b0;
    clr_vec = '0;
    if ((state_q == REQ) && ack_i && (32'(ack_code_i) < N_IRQ)) begin
      ack_ok = 1'b1;
    end
    for (int i = 0; i < N_IRQ; i++) begin
      clr_vec[i] = ack_ok && (32'(ack_code_i) == i);
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // --------------------------------------------------------------------------
  // Pending register and request FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      state_q   <= IDLE;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (|pend_masked) state_q <= REQ;
        end
        REQ: begin
          if (ack_ok)              state_q <= HOLD;
          else if (!(|pend_masked)) state_q <= IDLE;  // masked away, no clear
        end
        // One idle cycle so the encoder settles on the updated vector.
        HOLD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_valid_o   = (state_q == REQ);
  assign pend_out_o    = pend_masked;
  assign pending_raw_o = pending_q;

`ifdef IRQ_OVERRUN_CNT_EN
  // --------------------------------------------------------------------------
  // Overrun counter: a new edge landing on a bit that is still pending (and
  // not being cleared this cycle) means an event was merged and lost.
  // --------------------------------------------------------------------------
  logic       ovr_hit;
  logic [7:0] ovr_cnt_q;

  assign ovr_hit = |(set_vec & pending_q & ~clr_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt_q <= 8'd0;
    end else if (ovr_clr_i) begin
      ovr_cnt_q <= 8'd0;
    end else if (ovr_hit && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign overrun_cnt_o = ovr_cnt_q;
`endif

endmodule : irq_request_latch
`default_nettype wire

// File: tb/tb_irq_request_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_request_latch
// Description : Directed self-checking bench for irq_request_latch. Expected
//               values are queued when stimulus is applied and popped when
//               the corresponding DUT output is sampled.
// Options     : IRQ_OVERRUN_CNT_EN enables the overrun-counter steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_request_latch;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic [7:0] pend_out;
  logic       irq_valid;
  logic       ack;
  logic [2:0] ack_code;
  logic [7:0] pending_raw;
`ifdef IRQ_OVERRUN_CNT_EN
  logic       ovr_clr;
  logic [7:0] overrun_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  irq_request_latch #(
    .N_IRQ       (8),
    .CODE_W      (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef IRQ_OVERRUN_CNT_EN
    .ovr_clr_i     (ovr_clr),
    .overrun_cnt_o (overrun_cnt),
`endif
    .irq_in_i      (irq_in),
    .mask_i        (mask),
    .pend_out_o    (pend_out),
    .irq_valid_o   (irq_valid),
    .ack_i         (ack),
    .ack_code_i    (ack_code),
    .pending_raw_o (pending_raw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    irq_in   = 8'h00;
    mask     = 8'h00;
    ack      = 1'b0;
    ack_code = 3'd0;
`ifdef IRQ_OVERRUN_CNT_EN
    ovr_clr  = 1'b0;
`endif

    // ---------------- reset state ----------------
    #1;
    expect_val("rst_pending", 32'h00); check(32'(pending_raw));
    expect_val("rst_valid",   32'h0);  check(32'(irq_valid));
    expect_val("rst_pendout", 32'h00); check(32'(pend_out));
    tick(2);
    rst_n = 1'b1;
    tick(5);

    // ---------------- single request on line 5 ----------------
    mask   = 8'hFF;
    irq_in = 8'h20;
    expect_val("single_pend_e2", 32'h00);
    expect_val("single_pend_e3", 32'h20);
    expect_val("single_valid_e3", 32'h0);
    expect_val("single_valid_e4", 32'h1);
    tick(2); check(32'(pending_raw));
    tick(1); check(32'(pending_raw)); check(32'(irq_valid));
    irq_in = 8'h00;
    tick(1); check(32'(irq_valid));
    ack = 1'b1; ack_code = 3'd5;
    expect_val("single_ack_pend",  32'h00);
    expect_val("single_hold_valid", 32'h0);
    expect_val("single_ack_pendout", 32'h00);
    tick(1); check(32'(pending_raw)); check(32'(irq_valid)); check(32'(pend_out));
    ack = 1'b0;
    expect_val("single_idle_valid", 32'h0);
    expect_val("single_idle_valid2", 32'h0);
    tick(1); check(32'(irq_valid));
    tick(1); check(32'(irq_valid));

    // ---------------- priority drain 7,4,1 ----------------
    irq_in = 8'h92;
    expect_val("drain_pendout", 32'h92);
    tick(3); check(32'(pend_out));
    irq_in = 8'h00;
    expect_val("drain_valid0", 32'h1);
    tick(1); check(32'(irq_valid));
    ack = 1'b1; ack_code = 3'd7;
    expect_val("drain_after7", 32'h12);
    expect_val("drain_hold7",  32'h0);
    tick(1); check(32'(pend_out)); check(32'(irq_valid));
    ack = 1'b0;
    expect_val("drain_idle7", 32'h0);
    expect_val("drain_req4",  32'h1);
    tick(1); check(32'(irq_valid));
    tick(1); check(32'(irq_valid));
    ack = 1'b1; ack_code = 3'd4;
    expect_val("drain_after4", 32'h02);
    tick(1); check(32'(pend_out));
    ack = 1'b0;
    expect_val("drain_req1", 32'h1);
    tick(2); check(32'(irq_valid));
    ack = 1'b1; ack_code = 3'd1;
    expect_val("drain_after1", 32'h00);
    tick(1); check(32'(pend_out));
    ack = 1'b0;
    expect_val("drain_empty_valid", 32'h0);
    expect_val("drain_empty_valid2", 32'h0);
    tick(2); check(32'(irq_valid));
    tick(1); check(32'(irq_valid));

    // ---------------- mask behaviour on line 2 ----------------
    mask   = 8'h00;
    irq_in = 8'h04;
    expect_val("mask_pending", 32'h04);
    expect_val("mask_pendout", 32'h00);
    tick(3); check(32'(pending_raw)); check(32'(pend_out));
    irq_in = 8'h00;
    expect_val("mask_novalid", 32'h0);
    tick(1); check(32'(irq_valid));
    // ack outside REQ must be ignored
    ack = 1'b1; ack_code = 3'd2;
    expect_val("mask_idle_ack_pend",  32'h04);
    expect_val("mask_idle_ack_valid", 32'h0);
    tick(1); check(32'(pending_raw)); check(32'(irq_valid));
    ack = 1'b0;
    mask = 8'h04;
    expect_val("mask_unmask_pendout", 32'h04);
    #1; check(32'(pend_out));
    expect_val("mask_unmask_valid", 32'h1);
    tick(1); check(32'(irq_valid));
    mask = 8'h00;
    expect_val("mask_drop_valid",   32'h0);
    expect_val("mask_drop_pending", 32'h04);
    tick(1); check(32'(irq_valid)); check(32'(pending_raw));
    mask = 8'h04;
    expect_val("mask_rereq_valid", 32'h1);
    tick(1); check(32'(irq_valid));
    ack = 1'b1; ack_code = 3'd2;
    expect_val("mask_ack_pending", 32'h00);
    tick(1); check(32'(pending_raw));
    ack = 1'b0;
    tick(2);

    // ---------------- set/clear collision on line 3 ----------------
    mask   = 8'hFF;
    irq_in = 8'h08;
    expect_val("coll_pending", 32'h08);
    tick(3); check(32'(pending_raw));
    irq_in = 8'h00;
    expect_val("coll_req", 32'h1);
    tick(1); check(32'(irq_valid));
    tick(1);
    irq_in = 8'h08;
    tick(2);
    ack = 1'b1; ack_code = 3'd3;
    expect_val("coll_set_wins", 32'h08);
    expect_val("coll_hold",     32'h0);
    tick(1); check(32'(pending_raw)); check(32'(irq_valid));
    ack = 1'b0;
    irq_in = 8'h00;
    expect_val("coll_idle",  32'h0);
    expect_val("coll_rereq", 32'h1);
    tick(1); check(32'(irq_valid));
    tick(1); check(32'(irq_valid));
    ack = 1'b1; ack_code = 3'd3;
    expect_val("coll_cleared", 32'h00);
    tick(1); check(32'(pending_raw));
    ack = 1'b0;
    tick(2);

    // ---------------- asynchronous reset mid-stream ----------------
    irq_in = 8'hFF;
    expect_val("mrst_pre_pending", 32'hFF);
    expect_val("mrst_pre_valid",   32'h1);
    tick(3); check(32'(pending_raw));
    tick(1); check(32'(irq_valid));
    #2 rst_n = 1'b0;
    expect_val("mrst_pending", 32'h00);
    expect_val("mrst_valid",   32'h0);
    expect_val("mrst_pendout", 32'h00);
    #1; check(32'(pending_raw)); check(32'(irq_valid)); check(32'(pend_out));
    @(negedge clk);
    rst_n = 1'b1;
    expect_val("mrst_held_pending", 32'h00);
    expect_val("mrst_held_valid",   32'h0);
    tick(6); check(32'(pending_raw)); check(32'(irq_valid));
    irq_in = 8'h00;
    expect_val("mrst_fall_pending", 32'h00);
    tick(4); check(32'(pending_raw));

`ifdef IRQ_OVERRUN_CNT_EN
    // ---------------- overrun counter saturation and clear ----------------
    mask = 8'h00;
    expect_val("ovr_start", 32'h00);
    check(32'(overrun_cnt));
    for (int p = 0; p < 300; p++) begin
      irq_in = 8'h01;
      tick(2);
      irq_in = 8'h00;
      tick(2);
    end
    tick(4);
    expect_val("ovr_saturated", 32'hFF);
    check(32'(overrun_cnt));
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    expect_val("ovr_cleared", 32'h00);
    check(32'(overrun_cnt));
`endif

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d unchecked entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_irq_request_latch
`default_nettype wire
